// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and a FIFO of load returns onto one register-file write port,
// with a starvation guard for loads and a pending-load scoreboard for hazard queries.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               addr_1,
  input  logic [4:0]               addr_2,
  output logic                     busy_1,
  output logic                     busy_2,
  output logic [4:0]               addr_3,
  output logic                     write_enable_3,
  output logic [XLEN-1:0]          write_data_3,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {ALU_PRI, MEM_PRI} state_t;

  state_t          state_q, state_d;
  logic [1:0]      starve_q, starve_d;
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            fifo_empty, push, pop, alu_win;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign fifo_empty = (count_q == '0);
  // Full blocks a push even when the head pops in the same cycle.
  assign mem_ready  = (count_q < FULL_CNT);
  assign push       = mem_valid && mem_ready;
  assign head_rd    = fifo_rd_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];

  always_comb begin
    state_d   = ALU_PRI;
    starve_d  = '0;
    alu_ready = 1'b1;
    alu_win   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ALU_PRI: begin
        alu_win = alu_valid;
        pop     = !alu_valid && !fifo_empty;
        // Third consecutive cycle of the ALU beating a waiting load forces one load through.
        if (alu_valid && !fifo_empty) begin
          if (starve_q == 2'd2) state_d = MEM_PRI;
          else                  starve_d = starve_q + 2'd1;
        end
      end
      MEM_PRI: begin
        alu_ready = 1'b0;
        pop       = !fifo_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_win) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (pop) begin
      wr_en_d   = (head_rd != 5'd0);
      wr_addr_d = head_rd;
      wr_data_d = head_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ALU_PRI;
      starve_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= mem_rd;
      fifo_data_q[wptr_q] <= mem_data;
    end
  end

  assign busy_1         = (addr_1 != 5'd0) && busy_q[addr_1];
  assign busy_2         = (addr_2 != 5'd0) && busy_q[addr_2];
  assign addr_3         = wr_addr_q;
  assign write_enable_3 = wr_en_q;
  assign write_data_3   = wr_data_q;
  assign fifo_count     = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            alu_valid, alu_ready, mem_valid, mem_ready, issue_valid;
  logic [4:0]      alu_rd, mem_rd, issue_rd, addr_1, addr_2, addr_3;
  logic [XLEN-1:0] alu_data, mem_data, write_data_3;
  logic            busy_1, busy_2, write_enable_3;
  logic [CW-1:0]   fifo_count;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .addr_1(addr_1), .addr_2(addr_2), .busy_1(busy_1), .busy_2(busy_2),
    .addr_3(addr_3), .write_enable_3(write_enable_3), .write_data_3(write_data_3),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending loads as a queue, priority as a one-cycle "forced" flag.
  typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] data;} ent_t;
  ent_t            q[$];
  bit              m_forced = 0;
  int              m_starve = 0;
  bit [31:0]       m_busy = '0;
  bit              m_we = 0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;

  typedef struct {
    logic av; logic [4:0] rd; logic [31:0] data;
    logic we; logic [4:0] addr; logic [31:0] wd;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
    addr_1 = 0; addr_2 = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_forced = 0; m_starve = 0; m_busy = '0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    bit   alu_win, pop, push, forced_n;
    ent_t head;
    #1;
    chk("alu_ready", alu_ready, !m_forced);
    chk("mem_ready", mem_ready, q.size() < DEPTH);
    chk("busy_1", busy_1, (addr_1 != 0) && m_busy[addr_1]);
    chk("busy_2", busy_2, (addr_2 != 0) && m_busy[addr_2]);
    alu_win = !m_forced && alu_valid;
    pop     = (q.size() > 0) && (m_forced || !alu_valid);
    push    = mem_valid && (q.size() < DEPTH);
    m_we = 0;
    if (alu_win) begin
      m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
    end else if (pop) begin
      head = q[0];
      m_we = (head.rd != 0); m_addr = head.rd; m_data = head.data;
    end
    forced_n = 0;
    if (!m_forced && q.size() > 0 && alu_valid) begin
      m_starve++;
      if (m_starve == 3) begin forced_n = 1; m_starve = 0; end
    end else begin
      m_starve = 0;
    end
    m_forced = forced_n;
    if (pop) begin
      m_busy[q[0].rd] = 0;
      void'(q.pop_front());
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    if (push) q.push_back('{rd: mem_rd, data: mem_data});
    @(posedge clk); #1;
    chk("write_enable_3", write_enable_3, m_we);
    if (m_we) begin
      chk("addr_3", addr_3, m_addr);
      chk("write_data_3", write_data_3, m_data);
    end
    chk("fifo_count", fifo_count, q.size());
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd10, 32'd21,         1'b1, 5'd10, 32'd21};
    tbl[1] = '{1'b1, 5'd0,  32'd7,          1'b0, 5'd0,  32'd0};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  1'b1, 5'd31, 32'hFFFF_FFFF};
    tbl[3] = '{1'b0, 5'd3,  32'd5,          1'b0, 5'd0,  32'd0};
    tbl[4] = '{1'b1, 5'd1,  32'd0,          1'b1, 5'd1,  32'd0};

    idle();
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", write_enable_3, 0);
    chk("rst_addr", addr_3, 0);
    chk("rst_data", write_data_3, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    rstn = 1;

    // Single ALU writes from an empty FIFO
    foreach (tbl[i]) begin
      idle();
      alu_valid = tbl[i].av; alu_rd = tbl[i].rd; alu_data = tbl[i].data;
      cycle();
      chk("tbl_we", write_enable_3, tbl[i].we);
      if (tbl[i].we) begin
        chk("tbl_addr", addr_3, tbl[i].addr);
        chk("tbl_data", write_data_3, tbl[i].wd);
      end
      idle();
      cycle();
      chk("tbl_we_after", write_enable_3, 0);
    end

    // Issued load marks busy until its return is written
    idle(); issue_valid = 1; issue_rd = 5; addr_1 = 5;
    cycle();
    issue_valid = 0;
    chk("ld_busy_set", busy_1, 1);
    mem_valid = 1; mem_rd = 5; mem_data = 32'hDEAD_BEEF;
    cycle();
    mem_valid = 0;
    chk("ld_busy_held", busy_1, 1);
    cycle();
    chk("ld_we", write_enable_3, 1);
    chk("ld_addr", addr_3, 5);
    chk("ld_data", write_data_3, 32'hDEAD_BEEF);
    chk("ld_busy_clr", busy_1, 0);

    // Fill FIFO behind a continuously valid ALU; starvation forces one pop
    idle(); alu_valid = 1; alu_rd = 2;
    for (int i = 0; i < 4; i++) begin
      alu_data = i; mem_valid = 1; mem_rd = 5'(9 + i); mem_data = 100 + i;
      cycle();
    end
    chk("full_count", fifo_count, 4);
    chk("full_mem_ready", mem_ready, 0);
    chk("forced_alu_ready", alu_ready, 0);
    mem_rd = 20; mem_data = 999;
    cycle();
    chk("forced_we", write_enable_3, 1);
    chk("forced_addr", addr_3, 9);
    chk("forced_data", write_data_3, 100);
    chk("forced_count", fifo_count, 3);
    chk("forced_release", alu_ready, 1);
    idle();
    repeat (4) cycle();

    // Simultaneous push/pop and pointer wrap, values 1..6 in order
    idle(); alu_valid = 1; mem_valid = 1;
    for (int i = 1; i <= 6; i++) begin
      if (i > 2) alu_valid = 0;
      mem_rd = 5'(i); mem_data = i;
      cycle();
      if (i == 3) chk("pushpop_count", fifo_count, 2);
      if (i >= 3) chk("wrap_order", write_data_3, i - 2);
    end
    mem_valid = 0;
    for (int j = 5; j <= 6; j++) begin
      cycle();
      chk("wrap_order", write_data_3, j);
    end
    cycle();

    // Randomized traffic
    idle();
    for (int n = 0; n < 600; n++) begin
      if (!(m_forced && alu_valid)) begin
        alu_valid = ($urandom_range(0, 99) < 55);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      mem_valid   = ($urandom_range(0, 99) < 50);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom_range(0, 7));
      addr_1      = 5'($urandom_range(0, 7));
      addr_2      = 5'($urandom);
      cycle();
    end
    for (int n = 0; n < 8; n++) begin
      if (!(m_forced && alu_valid)) begin alu_valid = 0; end
      mem_valid = 0; issue_valid = 0;
      cycle();
    end

    // Reset mid-operation discards queued loads and pending busy bits
    idle(); issue_valid = 1; issue_rd = 8; alu_valid = 1; mem_valid = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin alu_rd = 12; alu_data = 55; end
      mem_rd = 5'(i + 1); mem_data = i + 1;
      cycle();
      issue_valid = 0;
    end
    idle(); addr_1 = 8;
    #1;
    chk("pre_rst_busy", busy_1, 1);
    chk("pre_rst_count", fifo_count, 3);
    #2 rstn = 0;
    #1;
    chk("mid_rst_we", write_enable_3, 0);
    chk("mid_rst_addr", addr_3, 0);
    chk("mid_rst_data", write_data_3, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy_1, 0);
    chk("mid_rst_mem_ready", mem_ready, 1);
    chk("mid_rst_alu_ready", alu_ready, 1);
    model_reset();
    mem_valid = 1; alu_valid = 1; alu_rd = 7; issue_valid = 1; issue_rd = 9;
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_rst_we", write_enable_3, 0);
      chk("in_rst_count", fifo_count, 0);
    end
    idle(); addr_1 = 8; addr_2 = 9;
    rstn = 1;
    cycle();
    chk("post_rst_busy", busy_1, 0);
    chk("post_rst_we", write_enable_3, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of every writeback value.
REQ-002 Parameter: DEPTH, 4, load-return FIFO entries (power of two, >= 2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rstn  input  1  asynchronous, active-low reset.
REQ-005 Port: alu_valid  input  1  ALU result offered this cycle.
REQ-006 Port: alu_ready  output  1  ALU result accepted this cycle.
REQ-007 Port: alu_rd / alu_data  input  5 / XLEN  ALU destination register and value.
REQ-008 Port: mem_valid  input  1  load return offered.
REQ-009 Port: mem_ready  output  1  FIFO can accept a load return.
REQ-010 Port: mem_rd / mem_data  input  5 / XLEN  load destination and value.
REQ-011 Port: issue_valid / issue_rd  input  1 / 5  load issued; mark issue_rd pending.
REQ-012 Port: addr_1 / addr_2  input  5 / 5  hazard query addresses (register-file read addresses).
REQ-013 Port: busy_1 / busy_2  output  1 / 1  queried register has a pending load.
REQ-014 Port: addr_3 / write_enable_3 / write_data_3  output  5 / 1 / XLEN  register-file write port.
REQ-015 Port: fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Write-port outputs SHALL be registered: a source accepted in cycle N appears on addr_3/write_data_3 with write_enable_3=1 in cycle N+1, held for one cycle.
REQ-017 At most one write SHALL be issued per cycle; with no accepted source, write_enable_3=0 next cycle.
REQ-018 Writes with rd=0 SHALL be accepted/popped normally but produce write_enable_3=0.
REQ-019 mem_ready SHALL be 1 iff fifo_count < DEPTH (combinational from count); push on mem_valid && mem_ready.
REQ-020 When full, mem_ready SHALL be 0 even if a pop occurs the same cycle.
REQ-021 FIFO SHALL be in-order; read/write pointers wrap modulo DEPTH; count updates +1 push, -1 pop, unchanged on simultaneous push and pop.
REQ-022 Arbitration states: ALU_PRI (default) and MEM_PRI.
REQ-023 ALU_PRI: alu_ready=1; if alu_valid, ALU wins; otherwise FIFO head pops if non-empty.
REQ-024 Starvation counter (2 bits) SHALL increment each cycle in ALU_PRI with FIFO non-empty and alu_valid=1, and clear otherwise.
REQ-025 When the counter reaches 3, next state SHALL be MEM_PRI and counter cleared.
REQ-026 MEM_PRI: alu_ready=0, FIFO head pops; state returns to ALU_PRI the following cycle (exactly one forced pop).
REQ-027 ALU source SHALL hold alu_valid/alu_rd/alu_data while alu_ready=0.
REQ-028 Scoreboard: 32-bit busy vector; issue_valid with issue_rd!=0 sets busy[issue_rd] on the clock edge.
REQ-029 A FIFO pop SHALL clear busy[rd of popped entry] on the same edge; set and clear of the same register on the same edge -> set wins.
REQ-030 busy_1 = busy[addr_1], busy_2 = busy[addr_2], combinational; address 0 always returns 0.
REQ-031 An ALU write does not alter busy.

Reset
REQ-032 rstn=0 SHALL immediately force: write_enable_3=0, addr_3=0, write_data_3=0, fifo_count=0, busy vector=0, state ALU_PRI, starvation counter=0.
REQ-033 During reset mem_ready SHALL be 1 and alu_ready 1; inputs are ignored.
REQ-034 Reset asserted mid-operation SHALL discard FIFO contents and pending busy bits without generating any write.

Verification
REQ-035 alu_valid=1, alu_rd=10, alu_data=21 for one cycle -> next cycle addr_3=10, write_data_3=21, write_enable_3=1; then 0.
REQ-036 issue_rd=5; later mem_valid with rd=5, data=0xDEADBEEF, alu idle -> busy_1=1 (addr_1=5) until the write cycle; write_enable_3=1, addr_3=5; busy_1=0 after.
REQ-037 Push 4 load returns with alu_valid held high -> mem_ready=0 at count 4; after 3 ALU-won cycles alu_ready=0 for one cycle and the oldest load is written.
REQ-038 Push + pop same cycle at count 2 -> count stays 2; FIFO order preserved across pointer wrap (push 6 entries, values 1..6, all written in order).
REQ-039 alu_rd=0, data=7 -> write_enable_3=0 next cycle; issue_rd=0 -> busy_1 stays 0 for addr_1=0.
REQ-040 Fill FIFO to 3, set busy[8], assert rstn=0 mid-cycle -> outputs zero immediately; after release count=0, busy_1=0 (addr_1=8), no write issued.
